muxn_scan: RTL and testbench
============================

Name: muxn_scan

Overview:
- N-channel, WIDTH-bit registered multiplexer; successor to the 8-bit 2:1 muxes.
- Two selection modes:
  - manual: channel loaded by a strobe.
  - scan: time-division auto-scan, dwelling DWELL cycles per channel and skipping channels whose valid bit is low.
- Sits between parallel data sources and a single shared consumer (display or serial path).
- Output, channel index and valid flag are all registered.

Parameters:
- WIDTH, 8, data width per channel.
- N, 4, number of input channels (2..16).
- DWELL, 4, cycles spent on each channel in scan mode (1..255).
- SEL_W (localparam) = clog2(N), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_bus  input  N*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
- in_valid  input  N  per-channel data-valid.
- mode  input  1  0 = manual, 1 = scan.
- sel  input  SEL_W  channel index for manual load.
- load_sel  input  1  strobe: capture sel in manual mode.
- freeze  input  1  hold all outputs and counters.
- out  output  WIDTH  selected data, registered.
- out_ch  output  SEL_W  index of channel currently driven.
- out_valid  output  1  in_valid of the driven channel, registered.
- sel_err  output  1  sticky flag: load_sel with sel >= N.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out = 0, out_ch = 0, out_valid = 0, sel_err = 0.
  - Dwell counter = 0, FSM = MAN.
- Latency: 1 cycle. Each edge:
  - out <= in_bus[cur*WIDTH +: WIDTH]
  - out_valid <= in_valid[cur]
  - out_ch <= cur
  - cur is the channel register value before the edge.
- FSM states: MAN, SCAN.
  - MAN -> SCAN when mode = 1: dwell counter cleared, cur unchanged.
  - SCAN -> MAN when mode = 0: cur unchanged, counter cleared.
- MAN:
  - load_sel = 1 and sel < N: cur <= sel. out reflects the new channel one cycle later (2 edges after the strobe).
  - load_sel = 1 and sel >= N: cur unchanged, sel_err <= 1.
  - sel_err is sticky; cleared only by reset.
- SCAN:
  - Counter increments each cycle.
  - When counter = DWELL-1: counter <= 0 and cur <= next channel (cur+1 .. cur+N-1, modulo N, searched in order) whose in_valid = 1.
  - No other channel valid: cur unchanged, counter still wraps.
  - All channels invalid: cur holds, out_valid = 0.
  - load_sel ignored in SCAN; sel_err not set.
- Wrap-around: index N-1 advances to 0; no out-of-range index is ever produced.
- freeze = 1 (highest priority after reset):
  - out, out_ch, out_valid, cur, counter and FSM state all hold.
  - load_sel and mode changes are ignored while frozen.
  - Mode is re-sampled on the first unfrozen edge.
- Simultaneous mode = 1 and load_sel = 1 in MAN: the transition to SCAN wins and the load is ignored.
- Reset mid-scan: immediate return to reset values; operation resumes in MAN, channel 0.
- Channel data change with selection fixed: appears on out after 1 cycle (pipeline register, no combinational path in to out).

Optional Feature:
- MUXN_SCAN_PARITY_EN
- Defined:
  - Extra output out_par (1 bit, registered with out) = even parity (XOR reduction) of the selected channel data. Reset value 0.
  - Extra input par_odd (1 bit): when 1, out_par is inverted (odd parity).
- Not defined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset check: rst_n = 0 asserted asynchronously mid-cycle -> out, out_ch, out_valid, sel_err are 0 immediately, without a clock edge.
- Manual select (N = 4, WIDTH = 8):
  - Stimulus: channels = 8'h11, 8'h22, 8'h33, 8'h44, all valid; load_sel with sel = 2.
  - Response: out = 8'h33, out_ch = 2, out_valid = 1 on the second edge after the strobe.
- Select error: N = 3, sel = 3 with load_sel -> sel_err = 1 and stays 1; out_ch unchanged; a following valid load still works.
- Scan with skip:
  - Stimulus: DWELL = 4, in_valid = 4'b1011, mode = 1 from channel 0.
  - Response: out_ch sequence 0,0,0,0,1,1,1,1,3,3,3,3,0... (channel 2 never appears).
- Scan with no valid channels: in_valid = 0 in scan -> out_ch constant, out_valid = 0; raising in_valid[1] -> channel 1 selected at the next dwell boundary.
- Freeze and mode race:
  - freeze = 1 for 6 cycles during scan -> outputs and dwell position hold, then the scan resumes mid-dwell.
  - mode = 1 together with load_sel in MAN -> enters SCAN, cur unchanged.

Source files
------------

// File: rtl/muxn_scan.sv
// muxn_scan: N-channel, WIDTH-bit registered multiplexer with manual and
// auto-scan channel selection. Output data, channel index and valid flag
// are registered with one cycle of latency from the channel register.
// Optional feature macro: MUXN_SCAN_PARITY_EN adds out_par / par_odd.
module muxn_scan #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned DWELL = 4,
    localparam int unsigned SEL_W = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_bus,
    input  logic [N-1:0]         in_valid,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 load_sel,
    input  logic                 freeze,
`ifdef MUXN_SCAN_PARITY_EN
    input  logic                 par_odd,
    output logic                 out_par,
`endif
    output logic [WIDTH-1:0]     out,
    output logic [SEL_W-1:0]     out_ch,
    output logic                 out_valid,
    output logic                 sel_err
);

    localparam int unsigned CNT_W = (DWELL <= 1) ? 1 : $clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W:0]   N_LIM    = (SEL_W + 1)'(N);

    localparam logic [0:0] ST_MAN  = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;
    logic [SEL_W-1:0] nxt_ch;
    logic             nxt_found;
    logic [WIDTH-1:0] cur_data;
`ifdef MUXN_SCAN_PARITY_EN
    logic             out_par_q, out_par_d;
`endif

    // Data of the channel currently held in the channel register.
    assign cur_data = in_bus[32'(cur_q)*WIDTH +: WIDTH];

    // Next valid channel after cur, searched in ascending order with wrap.
    always_comb begin
        nxt_ch    = cur_q;
        nxt_found = 1'b0;
        for (int unsigned i = 1; i < N; i++) begin
            if (!nxt_found && in_valid[(32'(cur_q) + i) % N]) begin
                nxt_ch    = SEL_W'((32'(cur_q) + i) % N);
                nxt_found = 1'b1;
            end
        end
    end

    // Next-state and output-register logic; freeze holds everything.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
`ifdef MUXN_SCAN_PARITY_EN
        out_par_d   = out_par_q;
`endif
        if (!freeze) begin
            out_d       = cur_data;
            out_ch_d    = cur_q;
            out_valid_d = in_valid[cur_q];
`ifdef MUXN_SCAN_PARITY_EN
            out_par_d   = (^cur_data) ^ par_odd;
`endif
            case (state_q)
                ST_MAN: begin
                    if (mode) begin
                        // Mode change wins over a simultaneous load strobe.
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                    end else if (load_sel) begin
                        if ({1'b0, sel} < N_LIM) begin
                            cur_d = sel;
                        end else begin
                            sel_err_d = 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (!mode) begin
                        state_d = ST_MAN;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        cur_d = nxt_ch;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_MAN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_MAN;
            cnt_q       <= '0;
            cur_q       <= '0;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
`ifdef MUXN_SCAN_PARITY_EN
            out_par_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
`ifdef MUXN_SCAN_PARITY_EN
            out_par_q   <= out_par_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
`ifdef MUXN_SCAN_PARITY_EN
    assign out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_muxn_scan.sv
// Self-checking bench for muxn_scan: directed steps plus a randomized phase,
// checked against a rule-level reference model. Instance a is N=4, instance
// b is N=3 (used for out-of-range select strobes).
module tb_muxn_scan;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] in_bus_a;
    logic [3:0]  in_valid_a;
    logic        mode_a, load_a, freeze_a;
    logic [1:0]  sel_a;
    logic [7:0]  out_a;
    logic [1:0]  out_ch_a;
    logic        out_valid_a, sel_err_a;

    logic [23:0] in_bus_b;
    logic [2:0]  in_valid_b;
    logic        mode_b, load_b, freeze_b;
    logic [1:0]  sel_b;
    logic [7:0]  out_b;
    logic [1:0]  out_ch_b;
    logic        out_valid_b, sel_err_b;
`ifdef MUXN_SCAN_PARITY_EN
    logic        par_odd_a, out_par_a, par_odd_b, out_par_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit scan;
        int cnt;
        int cur;
        int out;
        int ch;
        bit val;
        bit err;
    } mstate_t;

    mstate_t ma, mb;

    always #5 clk = ~clk;

    muxn_scan #(.WIDTH(8), .N(4), .DWELL(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus_a), .in_valid(in_valid_a),
        .mode(mode_a), .sel(sel_a), .load_sel(load_a), .freeze(freeze_a),
`ifdef MUXN_SCAN_PARITY_EN
        .par_odd(par_odd_a), .out_par(out_par_a),
`endif
        .out(out_a), .out_ch(out_ch_a), .out_valid(out_valid_a), .sel_err(sel_err_a)
    );

    muxn_scan #(.WIDTH(8), .N(3), .DWELL(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus_b), .in_valid(in_valid_b),
        .mode(mode_b), .sel(sel_b), .load_sel(load_b), .freeze(freeze_b),
`ifdef MUXN_SCAN_PARITY_EN
        .par_odd(par_odd_b), .out_par(out_par_b),
`endif
        .out(out_b), .out_ch(out_ch_b), .out_valid(out_valid_b), .sel_err(sel_err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic mreset(output mstate_t s);
        s = '{default: 0};
    endtask

    // Behaviour of one clock edge, written from the selection rules.
    task automatic model_step(input int n, input int dwell, input logic [63:0] bus,
                              input logic [15:0] valid, input bit mode, input int sel,
                              input bit load, input bit frz, inout mstate_t s);
        if (frz) return;
        s.out = int'((bus >> (s.cur * 8)) & 64'hFF);
        s.val = valid[s.cur];
        s.ch  = s.cur;
        if (!s.scan) begin
            if (mode) begin
                s.scan = 1;
                s.cnt  = 0;
            end else if (load) begin
                if (sel < n) s.cur = sel;
                else         s.err = 1;
            end
        end else begin
            if (!mode) begin
                s.scan = 0;
                s.cnt  = 0;
            end else if (s.cnt == dwell - 1) begin
                s.cnt = 0;
                for (int i = 1; i < n; i++) begin
                    if (valid[(s.cur + i) % n]) begin
                        s.cur = (s.cur + i) % n;
                        break;
                    end
                end
            end else begin
                s.cnt++;
            end
        end
    endtask

    task automatic check_all();
        check("a_out",       32'(out_a),       32'(ma.out));
        check("a_out_ch",    32'(out_ch_a),    32'(ma.ch));
        check("a_out_valid", 32'(out_valid_a), 32'(ma.val));
        check("a_sel_err",   32'(sel_err_a),   32'(ma.err));
        check("b_out",       32'(out_b),       32'(mb.out));
        check("b_out_ch",    32'(out_ch_b),    32'(mb.ch));
        check("b_sel_err",   32'(sel_err_b),   32'(mb.err));
    endtask

    task automatic step();
        @(posedge clk);
        model_step(4, 4, 64'(in_bus_a), 16'(in_valid_a), mode_a, int'(sel_a), load_a, freeze_a, ma);
        model_step(3, 4, 64'(in_bus_b), 16'(in_valid_b), mode_b, int'(sel_b), load_b, freeze_b, mb);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        mreset(ma);
        mreset(mb);
        check({tag, "_out"},       32'(out_a),       32'h0);
        check({tag, "_out_ch"},    32'(out_ch_a),    32'h0);
        check({tag, "_out_valid"}, 32'(out_valid_a), 32'h0);
        check({tag, "_sel_err_b"}, 32'(sel_err_b),   32'h0);
        check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int cnt2;
        bit got1;
        rst_n      = 1'b0;
        in_bus_a   = 32'h4433_2211;
        in_valid_a = 4'hF;
        mode_a = 0; load_a = 0; freeze_a = 0; sel_a = 0;
        in_bus_b   = 24'hCC_BBAA;
        in_valid_b = 3'b111;
        mode_b = 0; load_b = 0; freeze_b = 0; sel_b = 0;
`ifdef MUXN_SCAN_PARITY_EN
        par_odd_a = 0; par_odd_b = 0;
`endif
        mreset(ma);
        mreset(mb);
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        step();

        // Manual select of channel 2: visible on the second edge after strobe.
        sel_a = 2; load_a = 1;
        step();
        load_a = 0;
        step();
        check("man_out",   32'(out_a),       32'h33);
        check("man_ch",    32'(out_ch_a),    32'd2);
        check("man_valid", 32'(out_valid_a), 32'd1);

        // Out-of-range select on the 3-channel instance.
        sel_b = 2; load_b = 1;
        step();
        sel_b = 3;
        step();
        load_b = 0;
        step();
        check("err_set", 32'(sel_err_b), 32'd1);
        check("err_ch",  32'(out_ch_b),  32'd2);
        sel_b = 1; load_b = 1;
        step();
        load_b = 0;
        step();
        check("err_reload_ch", 32'(out_ch_b),  32'd1);
        check("err_sticky",    32'(sel_err_b), 32'd1);

        // Async reset mid-cycle with non-zero outputs.
        async_reset("rst1");

        // Scan with channel 2 invalid, starting from channel 0.
        in_valid_a = 4'b1011;
        mode_a = 1;
        cnt2 = 0;
        for (int i = 0; i < 26; i++) begin
            step();
            if (out_ch_a == 2'd2) cnt2++;
        end
        check("skip_ch2", 32'(cnt2), 32'd0);

        // No valid channel: hold; then channel 1 becomes valid.
        in_valid_a = 4'b0000;
        repeat (10) step();
        check("none_valid", 32'(out_valid_a), 32'd0);
        in_valid_a = 4'b0010;
        got1 = 0;
        for (int i = 0; i < 10 && !got1; i++) begin
            step();
            if (out_ch_a == 2'd1) got1 = 1;
        end
        check("none_then_ch1", 32'(got1), 32'd1);

        // Freeze during scan, with mode and load toggling underneath.
        in_valid_a = 4'b1111;
        repeat (2) step();
        freeze_a = 1;
        for (int i = 0; i < 6; i++) begin
            mode_a = 1'($urandom);
            load_a = 1'($urandom);
            sel_a  = 2'($urandom);
            in_bus_a = $urandom;
            step();
        end
        freeze_a = 0; mode_a = 1; load_a = 0;
        repeat (8) step();

        // Back to manual, pick channel 3, then mode and load on the same edge.
        mode_a = 0;
        step();
        sel_a = 3; load_a = 1;
        step();
        load_a = 0;
        step();
        mode_a = 1; load_a = 1; sel_a = 1;
        step();
        load_a = 0;
        step();
        check("race_ch", 32'(out_ch_a), 32'd3);

        // Randomized phase on both instances.
        for (int i = 0; i < 400; i++) begin
            in_bus_a   = $urandom;
            in_valid_a = 4'($urandom);
            mode_a     = ($urandom_range(0, 9) < 3);
            load_a     = 1'($urandom);
            sel_a      = 2'($urandom);
            freeze_a   = ($urandom_range(0, 9) == 0);
            in_bus_b   = 24'($urandom);
            in_valid_b = 3'($urandom);
            mode_b     = ($urandom_range(0, 9) < 3);
            load_b     = ($urandom_range(0, 3) == 0);
            sel_b      = 2'($urandom);
            freeze_b   = ($urandom_range(0, 9) == 0);
            step();
            if (i == 200) async_reset("rst2");
        end

        // Reset in the middle of a scan, then resume in manual on channel 0.
        mode_a = 1; freeze_a = 0; in_valid_a = 4'hF;
        repeat (6) step();
        async_reset("rst3");
        mode_a = 0; load_a = 0;
        repeat (2) step();
        check("resume_ch", 32'(out_ch_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
